// File: rtl/f8_board_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : f8_board_pkg
//  Description : Shared types and constants for the f8 board reset/clock-enable
//                sequencer: reset cause encoding, trap-handling modes,
//                sequencer states and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package f8_board_pkg;

   typedef enum logic [1:0] {
      CAUSE_POR    = 2'd0,
      CAUSE_BUTTON = 2'd1,
      CAUSE_TRAP   = 2'd2
   } reset_cause_t;

   localparam int TRAP_IGNORE = 0;
   localparam int TRAP_RESET  = 1;
   localparam int TRAP_HALT   = 2;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RUN     = 2'd1,
      TRAPPED = 2'd2
   } rstseq_state_t;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchroniser plus debounce counter for an active-low
//                push button. The stable level only follows the synchronised
//                input after it has differed for DEBOUNCE_CYCLES clocks.
//  Ports       : clk         - board clock
//                reset_n     - synchronous active-low reset
//                btn_n       - raw asynchronous button, low = pressed
//                btn_pressed - debounced level, high = pressed (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce
   import f8_board_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_n,
   output logic btn_pressed
);

   localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync0_q, sync0_d;
   logic             sync1_q, sync1_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync0_d  = btn_n;
      sync1_d  = sync0_q;
      stable_d = stable_q;
      cnt_d    = '0;
      // Any cycle where the input agrees with the stable value restarts the
      // qualification window, so only an unbroken run can flip stable.
      if (sync1_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync1_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync0_q  <= 1'b1;
         sync1_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         sync0_q  <= sync0_d;
         sync1_q  <= sync1_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign btn_pressed = ~stable_q;

endmodule
`default_nettype wire

// File: rtl/board_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : board_reset_ctrl
//  Description : Clock-enable divider and reset sequencer for f8 board tops.
//                Produces a one-cycle clk_en every CLKDIV clocks, debounces
//                the reset button, stretches system reset over HOLD_CYCLES
//                clk_en pulses and handles the core trap line per TRAP_MODE.
//  Ports       : clk, reset_n   - board clock, synchronous active-low reset
//                btn_n          - raw button, low = pressed
//                trap           - trap request from the system
//                clk_en         - divided clock enable pulse
//                sys_reset      - active-high system reset
//                halted         - high while halted after a trap
//                btn_pressed    - debounced button level
//                reset_cause    - 0 POR, 1 BUTTON, 2 TRAP
//  Revision    : 1.0  initial release
// ============================================================================
module board_reset_ctrl
   import f8_board_pkg::*;
#(
   parameter int CLKDIV          = 6,
   parameter int DEBOUNCE_CYCLES = 12000,
   parameter int HOLD_CYCLES     = 16,
   parameter int TRAP_MODE       = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_n,
   input  logic       trap,
   output logic       clk_en,
   output logic       sys_reset,
   output logic       halted,
   output logic       btn_pressed,
   output logic [1:0] reset_cause
);

   localparam int               DIV_W    = cnt_width(CLKDIV);
   localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLKDIV - 1);
   localparam int               HOLD_W   = cnt_width(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
   // Unsupported modes fall back to ignoring the trap line.
   localparam int TRAP_EFF = (TRAP_MODE == TRAP_RESET || TRAP_MODE == TRAP_HALT)
                             ? TRAP_MODE : TRAP_IGNORE;

   if (TRAP_MODE < 0 || TRAP_MODE > 2) begin : g_bad_trap_mode
      $error("board_reset_ctrl: TRAP_MODE %0d unsupported, trap ignored", TRAP_MODE);
   end

   logic [DIV_W-1:0]  div_q, div_d;
   logic              clk_en_q, clk_en_d;
   rstseq_state_t     state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              sys_reset_q, sys_reset_d;
   logic              halted_q, halted_d;
   reset_cause_t      cause_q, cause_d;
   logic              btn_prev_q, btn_prev_d;
   logic              btn_level;
   logic              btn_rise;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_n       (btn_n),
      .btn_pressed (btn_level)
   );

   // Divider: clk_en is registered, so it follows the terminal count by one clock.
   always_comb begin
      div_d    = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      clk_en_d = (div_q == DIV_MAX);
   end

   // Sequencer: transitions every clock, hold counter only on clk_en.
   always_comb begin
      btn_prev_d = btn_level;
      btn_rise   = btn_level & ~btn_prev_q;
      state_d    = state_q;
      hold_d     = hold_q;
      cause_d    = cause_q;
      case (state_q)
         HOLD: begin
            if (btn_level) begin
               hold_d = HOLD_MAX;
            end else if (clk_en_q) begin
               if (hold_q != '0) begin
                  hold_d = hold_q - 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // Button has priority over a simultaneous trap.
            if (btn_rise) begin
               state_d = HOLD;
               hold_d  = HOLD_MAX;
               cause_d = CAUSE_BUTTON;
            end else if (trap && TRAP_EFF == TRAP_RESET) begin
               state_d = HOLD;
               hold_d  = HOLD_MAX;
               cause_d = CAUSE_TRAP;
            end else if (trap && TRAP_EFF == TRAP_HALT) begin
               state_d = TRAPPED;
            end
         end
         TRAPPED: begin
            if (btn_rise) begin
               state_d = HOLD;
               hold_d  = HOLD_MAX;
               cause_d = CAUSE_BUTTON;
            end
         end
         default: begin
            state_d = HOLD;
            hold_d  = HOLD_MAX;
         end
      endcase
      // Outputs decode the next state so they change on the same edge.
      sys_reset_d = (state_d == HOLD);
      halted_d    = (state_d == TRAPPED);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_q       <= '0;
         clk_en_q    <= 1'b0;
         state_q     <= HOLD;
         hold_q      <= HOLD_MAX;
         sys_reset_q <= 1'b1;
         halted_q    <= 1'b0;
         cause_q     <= CAUSE_POR;
         btn_prev_q  <= 1'b0;
      end else begin
         div_q       <= div_d;
         clk_en_q    <= clk_en_d;
         state_q     <= state_d;
         hold_q      <= hold_d;
         sys_reset_q <= sys_reset_d;
         halted_q    <= halted_d;
         cause_q     <= cause_d;
         btn_prev_q  <= btn_prev_d;
      end
   end

   assign clk_en      = clk_en_q;
   assign sys_reset   = sys_reset_q;
   assign halted      = halted_q;
   assign btn_pressed = btn_level;
   assign reset_cause = cause_q;

endmodule
`default_nettype wire

// File: doc/board_reset_ctrl.md
Name: board_reset_ctrl

Overview:
- Parametrised clock-enable and reset sequencer for f8 board tops; replaces the fixed clkdiv plus raw button-to-reset wiring.
- Generates a divided clock enable for system.
- Debounces the active-low reset button.
- Stretches resets to a programmable number of enabled cycles.
- Reacts to the core trap line per a configurable mode: ignore, reset or halt.
- Sits between board pins (CLK, BTN_N) and system.

Parameters:
- CLKDIV, 6: clk cycles per clk_en pulse; must be >= 1. Counter width is $clog2(CLKDIV) with a minimum of 1.
- DEBOUNCE_CYCLES, 12000: consecutive clk cycles the synchronised button must differ from its stable value before the stable value changes; >= 1.
- HOLD_CYCLES, 16: clk_en pulses for which sys_reset is held after any reset cause; >= 1.
- TRAP_MODE, 1: 0 = ignore trap, 1 = trap causes reset, 2 = trap halts the core until the button is pressed.

Ports:
- clk, input, 1: board clock, the only clock.
- reset_n, input, 1: reset, synchronous, active-low.
- btn_n, input, 1: raw asynchronous button, low = pressed.
- trap, input, 1: trap from system, sampled in clk domain.
- clk_en, output, 1: one-cycle enable pulse every CLKDIV clocks.
- sys_reset, output, 1: active-high reset to system.
- halted, output, 1: high while in TRAPPED.
- btn_pressed, output, 1: debounced button level, high = pressed.
- reset_cause, output, 2: cause of the last reset. 0 = POR, 1 = BUTTON, 2 = TRAP.

Behaviour:
- Reset (reset_n low at a clk edge) sets:
  - div counter = 0, clk_en = 0.
  - Both synchroniser flops = 1; debounce counter = 0; stable = 1, so btn_pressed = 0.
  - State = HOLD, hold counter = HOLD_CYCLES-1, sys_reset = 1, halted = 0, reset_cause = POR.
- Reset dominates every other input. Assertion mid-operation restarts the whole sequence with cause POR.
- Divider:
  - Counter counts 0..CLKDIV-1 and wraps to 0.
  - clk_en is registered and high in the cycle after the counter equals CLKDIV-1.
  - With CLKDIV = 1, clk_en = 1 every cycle after the first post-reset edge.
- Button path:
  - Two-flop synchroniser, then a debounce counter.
  - If sync != stable, the counter increments. When it reaches DEBOUNCE_CYCLES-1 with sync still different, stable <= sync and the counter clears.
  - If sync == stable, the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
  - Latency from pin to btn_pressed = 2 + DEBOUNCE_CYCLES clk.
- Sequencer states: HOLD, RUN, TRAPPED. State changes are evaluated every clk; the hold counter moves only on clk_en.
  - HOLD: sys_reset = 1.
    - While btn_pressed is high, the hold counter reloads to HOLD_CYCLES-1.
    - Otherwise, on clk_en: a nonzero counter decrements; a zero counter moves to RUN.
    - sys_reset is therefore high for exactly HOLD_CYCLES clk_en pulses after release, and always falls on the edge closing a clk_en cycle.
  - RUN: sys_reset = 0.
    - Rising btn_pressed -> HOLD, reload counter, cause = BUTTON.
    - Else trap with TRAP_MODE 1 -> HOLD, reload, cause = TRAP.
    - Else trap with TRAP_MODE 2 -> TRAPPED.
    - Button beats trap on the same cycle.
  - TRAPPED: sys_reset = 0, halted = 1, cause unchanged.
    - Rising btn_pressed -> HOLD, cause = BUTTON.
    - trap is ignored.
- All outputs are registered. reset_cause updates in the same edge as the entry into HOLD.
- TRAP_MODE values other than 0/1/2 behave as 0 and raise an elaboration $error.

Decomposition:
- Package f8_board_pkg holds:
  - reset_cause_t enum (CAUSE_POR = 0, CAUSE_BUTTON = 1, CAUSE_TRAP = 2).
  - Constants TRAP_IGNORE = 0, TRAP_RESET = 1, TRAP_HALT = 2.
  - rstseq_state_t enum (HOLD, RUN, TRAPPED).
- One sub-module, btn_debounce, containing the synchroniser and debounce counter, parametrised by DEBOUNCE_CYCLES.
- Divider and sequencer stay in board_reset_ctrl.

Test Plan:
All scenarios use CLKDIV = 3, DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 2, TRAP_MODE = 1, and count cycles from the first edge with reset_n high (cycle 0).
- Release reset_n, btn_n = 1 -> clk_en high in cycles 3, 6, 9…; sys_reset 1 through cycle 6 and 0 from cycle 7; reset_cause = 0.
- In RUN, drive btn_n low for 3 cycles -> btn_pressed stays 0 and sys_reset stays 0.
- In RUN, drive btn_n low for 10 cycles -> btn_pressed rises 6 cycles after the fall; sys_reset = 1 and reset_cause = 1 on the next edge. After release and debounce, sys_reset stays high for exactly 2 more clk_en pulses.
- In RUN, pulse trap for 1 cycle -> sys_reset = 1 and reset_cause = 2 next edge; back to RUN after 2 clk_en pulses.
- With TRAP_MODE = 2, pulse trap -> halted = 1 and sys_reset = 0. Further traps do nothing. Pressing the button for 10 cycles gives halted = 0, sys_reset = 1, reset_cause = 1.
- Trap and debounced press on the same cycle -> reset_cause = 1. Pulsing reset_n low mid-HOLD -> reset_cause = 0, counters restart.
